// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory requester.
// Op encodings, FSM states and default widths.
package dmem_ctrl_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;
    localparam int DMEM_LW = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_FILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_CP_RD,
        ST_CP_WR,
        ST_FILL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_xfer_counter.sv
// Block-transfer byte index with last flag.
// Produces wrapped source/destination addresses.
module dmem_xfer_counter #(
    parameter int AW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    input  logic [LW-1:0] len,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    output logic [LW-1:0] idx,
    output logic          last,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + LW'(1);
        end
    end

    assign last     = (idx == len - LW'(1));
    assign src_addr = src_base + AW'(idx);
    assign dst_addr = dst_base + AW'(idx);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Requester FSM for the 256x8 data memory.
// Serves LOAD/STORE and multi-cycle COPY/FILL.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW,
    parameter int LW = DMEM_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_src,
    input  logic [LW-1:0] req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state, state_n;
    logic [AW-1:0] addr_q, src_q;
    logic [LW-1:0] len_q;
    logic [DW-1:0] wdata_q, buf_q, rsp_n;
    logic          accept, cnt_inc, last;
    logic [LW-1:0] idx;
    logic [AW-1:0] src_addr, dst_addr;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    dmem_xfer_counter #(.AW(AW), .LW(LW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .inc      (cnt_inc),
        .len      (len_q),
        .src_base (src_q),
        .dst_base (addr_q),
        .idx      (idx),
        .last     (last),
        .src_addr (src_addr),
        .dst_addr (dst_addr)
    );

    always_comb begin
        state_n   = state;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_LOAD:  state_n = ST_LOAD;
                        OP_STORE: state_n = ST_STORE;
                        OP_COPY:  state_n = (req_len == '0) ? ST_RESP : ST_CP_RD;
                        OP_FILL:  state_n = (req_len == '0) ? ST_RESP : ST_FILL;
                        default:  state_n = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                mem_addr = addr_q;
                state_n  = ST_RESP;
            end
            ST_STORE: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wen   = 1'b1;
                state_n   = ST_RESP;
            end
            ST_CP_RD: begin
                mem_addr = src_addr;
                state_n  = ST_CP_WR;
            end
            ST_CP_WR: begin
                mem_addr  = dst_addr;
                mem_wdata = buf_q;
                mem_wen   = 1'b1;
                cnt_inc   = !last;
                state_n   = last ? ST_RESP : ST_CP_RD;
            end
            ST_FILL: begin
                mem_addr  = dst_addr;
                mem_wdata = wdata_q;
                mem_wen   = 1'b1;
                cnt_inc   = !last;
                state_n   = last ? ST_RESP : ST_FILL;
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Zero-length block ops reach RESP straight from IDLE and report 0.
    always_comb begin
        rsp_n = '0;
        case (state)
            ST_LOAD:           rsp_n = mem_rdata;
            ST_CP_WR, ST_FILL: rsp_n = DW'(len_q);
            default:           rsp_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            src_q    <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q  <= req_addr;
                src_q   <= req_src;
                len_q   <= req_len;
                wdata_q <= req_wdata;
            end
            if (state == ST_CP_RD) begin
                buf_q <= mem_rdata;
            end
            if (state_n == ST_RESP && state != ST_RESP) begin
                rsp_data <= rsp_n;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a
// behavioural 256x8 data memory model.
module tb_dmem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_src = 8'h00;
    logic [7:0] req_len = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       mem_wen;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    int         wen_cnt = 0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    dmem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_src   (req_src),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen) begin
            mem[mem_addr] <= mem_wdata;
            wen_cnt <= wen_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare every response pulse.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_data", int'(rsp_data), int'(e.data));
                check("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] src, input logic [7:0] len,
                         input logic [7:0] wd, input logic [7:0] exp_d,
                         input int lat, input int exp_wen, input bit hold);
        int t;
        int w0;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_src   = src;
        req_len   = len;
        req_wdata = wd;
        e.data = exp_d;
        e.at   = cyc + lat;
        sb.push_back(e);
        w0 = wen_cnt;
        @(posedge clk);
        #1;
        if (hold) begin
            req_op    = 2'b01;
            req_addr  = 8'h00;
            req_wdata = 8'hFF;
        end else begin
            req_valid = 1'b0;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid && t < 600);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wen_cycles", wen_cnt - w0, exp_wen);
    endtask

    initial begin
        int t;
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'hC0 + 8'(i);

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mem_wen", int'(mem_wen), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);

        issue(2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hA5, 2, 0, 1'b0);
        issue(2'b01, 8'h3C, 8'h00, 8'h00, 8'h7E, 8'h00, 2, 1, 1'b0);
        issue(2'b00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h7E, 2, 0, 1'b0);

        issue(2'b10, 8'h80, 8'h00, 8'd4, 8'h00, 8'h04, 9, 4, 1'b0);
        check("copy_80", int'(mem[8'h80]), 'h11);
        check("copy_81", int'(mem[8'h81]), 'h22);
        check("copy_82", int'(mem[8'h82]), 'h33);
        check("copy_83", int'(mem[8'h83]), 'h44);

        issue(2'b11, 8'hFE, 8'h00, 8'd4, 8'h5A, 8'h04, 5, 4, 1'b0);
        check("fill_FE", int'(mem[8'hFE]), 'h5A);
        check("fill_FF", int'(mem[8'hFF]), 'h5A);
        check("fill_00", int'(mem[8'h00]), 'h5A);
        check("fill_01", int'(mem[8'h01]), 'h5A);
        check("fill_02_kept", int'(mem[8'h02]), 'h33);

        issue(2'b10, 8'h50, 8'h00, 8'd0, 8'h00, 8'h00, 1, 0, 1'b1);
        issue(2'b11, 8'h50, 8'h00, 8'd0, 8'h77, 8'h00, 1, 0, 1'b1);
        issue(2'b11, 8'h40, 8'h00, 8'd1, 8'h99, 8'h01, 2, 1, 1'b1);
        check("fill_40", int'(mem[8'h40]), 'h99);
        check("held_req_ignored", int'(mem[8'h00]), 'h5A);

        // Abort a COPY of 8 bytes while the 4th write is on the bus.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 8'h90;
        req_src   = 8'h20;
        req_len   = 8'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w0 = wen_cnt;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(mem_wen && wen_cnt - w0 == 3) && t < 100);
        check("abort_reached", int'(mem_wen), 1);
        rst_n = 1'b0;
        #1;
        check("abort_wen", int'(mem_wen), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_rsp_data", int'(rsp_data), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_90", int'(mem[8'h90]), 'hC0);
        check("abort_91", int'(mem[8'h91]), 'hC1);
        check("abort_92", int'(mem[8'h92]), 'hC2);
        check("abort_93", int'(mem[8'h93]), 'h00);
        check("abort_wen_total", wen_cnt - w0, 3);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
